// File: rtl/aes_lockstep_checker.sv
// rtl/aes_lockstep_checker.sv - lockstep comparator for two aes_core output streams
// Skew FIFOs absorb A/B arrival offset; first mismatch latches evidence and freezes the checker.
module aes_lockstep_checker #(
  parameter int DW      = 128,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_valid_i,
  input  logic [DW-1:0]   a_data_i,
  input  logic            b_valid_i,
  input  logic [DW-1:0]   b_data_i,
  input  logic            enable_i,
  input  logic            clear_i,
  output logic            alarm_o,
  output logic            overflow_o,
  output logic            timeout_o,
  output logic [CNTW-1:0] count_o,
  output logic [CNTW-1:0] fail_idx_o,
  output logic [DW-1:0]   fail_a_o,
  output logic [DW-1:0]   fail_b_o,
  output logic [DW-1:0]   fail_diff_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]     PTR_ONE   = 1;
  localparam logic [SW-1:0]   SKEW_ONE  = 1;
  localparam logic [SW-1:0]   SKEW_LAST = SW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = 1;

  typedef enum logic [1:0] {ST_RUN, ST_ALARM, ST_FAULT} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_a [DEPTH];
  logic [DW-1:0]   mem_b [DEPTH];
  logic [AW:0]     wptr_a_q, wptr_a_d, rptr_a_q, rptr_a_d;
  logic [AW:0]     wptr_b_q, wptr_b_d, rptr_b_q, rptr_b_d;
  logic [SW-1:0]   skew_q, skew_d;
  logic [CNTW-1:0] count_q, count_d, fail_idx_q, fail_idx_d;
  logic [DW-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic            alarm_q, alarm_d, overflow_q, overflow_d, timeout_q, timeout_d;

  logic run, empty_a, empty_b, full_a, full_b, pop, push_a, push_b;
  logic wr_a, wr_b, ovf_evt, mism, one_sided, timeout_evt;
  logic [DW-1:0] head_a, head_b;

  always_comb begin
    run         = (state_q == ST_RUN);
    empty_a     = (wptr_a_q == rptr_a_q);
    empty_b     = (wptr_b_q == rptr_b_q);
    full_a      = (wptr_a_q[AW] != rptr_a_q[AW]) && (wptr_a_q[AW-1:0] == rptr_a_q[AW-1:0]);
    full_b      = (wptr_b_q[AW] != rptr_b_q[AW]) && (wptr_b_q[AW-1:0] == rptr_b_q[AW-1:0]);
    pop         = run && !empty_a && !empty_b;
    push_a      = run && enable_i && a_valid_i;
    push_b      = run && enable_i && b_valid_i;
    // A full FIFO frees its head slot when popping, so the push still fits.
    wr_a        = push_a && (!full_a || pop);
    wr_b        = push_b && (!full_b || pop);
    ovf_evt     = (push_a && full_a && !pop) || (push_b && full_b && !pop);
    head_a      = mem_a[rptr_a_q[AW-1:0]];
    head_b      = mem_b[rptr_b_q[AW-1:0]];
    mism        = pop && (head_a != head_b);
    one_sided   = run && (empty_a != empty_b);
    timeout_evt = one_sided && (skew_q == SKEW_LAST);

    state_d    = state_q;
    wptr_a_d   = wptr_a_q;
    rptr_a_d   = rptr_a_q;
    wptr_b_d   = wptr_b_q;
    rptr_b_d   = rptr_b_q;
    skew_d     = skew_q;
    count_d    = count_q;
    fail_idx_d = fail_idx_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    alarm_d    = alarm_q | mism;
    overflow_d = overflow_q | ovf_evt;
    timeout_d  = timeout_q | timeout_evt;

    if (wr_a) wptr_a_d = wptr_a_q + PTR_ONE;
    if (wr_b) wptr_b_d = wptr_b_q + PTR_ONE;
    if (pop) begin
      rptr_a_d = rptr_a_q + PTR_ONE;
      rptr_b_d = rptr_b_q + PTR_ONE;
      count_d  = (count_q == {CNTW{1'b1}}) ? count_q : count_q + CNT_ONE;
    end
    if (run) skew_d = one_sided ? skew_q + SKEW_ONE : '0;

    // Mismatch wins over a same-cycle fault so the evidence is always captured.
    if (mism) begin
      state_d    = ST_ALARM;
      fail_idx_d = count_d;
      fail_a_d   = head_a;
      fail_b_d   = head_b;
    end else if (run && (ovf_evt || timeout_evt)) begin
      state_d = ST_FAULT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      state_q    <= ST_RUN;
      wptr_a_q   <= '0;
      rptr_a_q   <= '0;
      wptr_b_q   <= '0;
      rptr_b_q   <= '0;
      skew_q     <= '0;
      count_q    <= '0;
      fail_idx_q <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      alarm_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_a_q   <= wptr_a_d;
      rptr_a_q   <= rptr_a_d;
      wptr_b_q   <= wptr_b_d;
      rptr_b_q   <= rptr_b_d;
      skew_q     <= skew_d;
      count_q    <= count_d;
      fail_idx_q <= fail_idx_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      alarm_q    <= alarm_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_a) mem_a[wptr_a_q[AW-1:0]] <= a_data_i;
    if (wr_b) mem_b[wptr_b_q[AW-1:0]] <= b_data_i;
  end

  assign alarm_o     = alarm_q;
  assign overflow_o  = overflow_q;
  assign timeout_o   = timeout_q;
  assign count_o     = count_q;
  assign fail_idx_o  = fail_idx_q;
  assign fail_a_o    = fail_a_q;
  assign fail_b_o    = fail_b_q;
  assign fail_diff_o = fail_a_q ^ fail_b_q;

endmodule

// File: tb/tb_aes_lockstep_checker.sv
// tb/tb_aes_lockstep_checker.sv - directed-vector bench for aes_lockstep_checker
module tb_aes_lockstep_checker;

  localparam int DW      = 128;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 32;
  localparam logic [DW-1:0] FIPS_CT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic [DW-1:0]   a_data = '0, b_data = '0;
  logic            enable = 1'b1, clear = 1'b0;
  logic            alarm, overflow, timeout;
  logic [CNTW-1:0] count, fail_idx;
  logic [DW-1:0]   fail_a, fail_b, fail_diff;

  int vectors = 0;
  int miscompares = 0;

  aes_lockstep_checker #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_data_i(b_data),
    .enable_i(enable), .clear_i(clear),
    .alarm_o(alarm), .overflow_o(overflow), .timeout_o(timeout),
    .count_o(count), .fail_idx_o(fail_idx),
    .fail_a_o(fail_a), .fail_b_o(fail_b), .fail_diff_o(fail_diff)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] blk(input int i);
    return FIPS_CT ^ DW'(i * 32'h0101_0101);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({alarm, overflow, timeout} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=000", {alarm, overflow, timeout});
    end
    vectors++;
    if (count !== '0 || fail_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_count got=%0d/%0d exp=0/0", count, fail_idx);
    end
    vectors++;
    if (fail_a !== '0 || fail_b !== '0 || fail_diff !== '0) begin
      miscompares++;
      $display("FAIL reset_evidence got a=%h b=%h exp 0", fail_a, fail_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_pair();
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = FIPS_CT; b_data = FIPS_CT;
    tick();
    idle();
    vectors++;
    if (count !== 32'd0) begin
      miscompares++;
      $display("FAIL fips_latency count got=%0d exp=0", count);
    end
    tick();
    vectors++;
    if (count !== 32'd1 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_pair count=%0d alarm=%b exp 1/0", count, alarm);
    end
  endtask

  task automatic test_lagged_stream();
    do_clear();
    for (int c = 0; c < 16; c++) begin
      a_valid = (c < 10);
      a_data  = blk(c);
      b_valid = (c >= 3) && (c < 13);
      b_data  = blk(c - 3);
      tick();
    end
    idle();
    vectors++;
    if (count !== 32'd10) begin
      miscompares++;
      $display("FAIL lagged_count got=%0d exp=10", count);
    end
    vectors++;
    if ({alarm, overflow, timeout} !== 3'b000) begin
      miscompares++;
      $display("FAIL lagged_flags got=%b exp=000", {alarm, overflow, timeout});
    end
  endtask

  task automatic test_mismatch();
    do_clear();
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data  = blk(i);
      b_data  = (i == 5) ? (blk(i) ^ DW'(1)) : blk(i);
      tick();
    end
    idle();
    repeat (3) tick();
    vectors++;
    if (alarm !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mismatch_flags alarm=%b ovf=%b exp 1/0", alarm, overflow);
    end
    vectors++;
    if (fail_idx !== 32'd5) begin
      miscompares++;
      $display("FAIL mismatch_idx got=%0d exp=5", fail_idx);
    end
    vectors++;
    if (fail_diff !== DW'(1)) begin
      miscompares++;
      $display("FAIL mismatch_diff got=%h exp=1", fail_diff);
    end
    vectors++;
    if (fail_a !== blk(5) || fail_b !== (blk(5) ^ DW'(1))) begin
      miscompares++;
      $display("FAIL mismatch_evidence a=%h b=%h exp a=%h", fail_a, fail_b, blk(5));
    end
    vectors++;
    if (count !== 32'd5) begin
      miscompares++;
      $display("FAIL mismatch_count_frozen got=%0d exp=5", count);
    end
  endtask

  task automatic test_clear_recovery();
    do_clear();
    vectors++;
    if ({alarm, overflow, timeout} !== 3'b000 || count !== '0) begin
      miscompares++;
      $display("FAIL clear_state flags=%b count=%0d exp 000/0", {alarm, overflow, timeout}, count);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = blk(42); b_data = blk(42);
    tick();
    idle();
    tick();
    vectors++;
    if (count !== 32'd1 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_pair count=%0d alarm=%b exp 1/0", count, alarm);
    end
    vectors++;
    if (fail_idx !== '0 || fail_a !== '0 || fail_b !== '0 || fail_diff !== '0) begin
      miscompares++;
      $display("FAIL clear_evidence idx=%0d a=%h exp 0", fail_idx, fail_a);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i <= DEPTH; i++) begin
      a_valid = 1'b1;
      a_data  = blk(i);
      tick();
      if (i == DEPTH - 1) begin
        vectors++;
        if (overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL overflow_early got=%b exp=0", overflow);
        end
      end
    end
    idle();
    vectors++;
    if (overflow !== 1'b1 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_flag ovf=%b alarm=%b exp 1/0", overflow, alarm);
    end
    b_valid = 1'b1;
    b_data  = blk(0);
    repeat (2) tick();
    idle();
    repeat (TIMEOUT + 4) tick();
    vectors++;
    if (count !== '0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_frozen count=%0d timeout=%b exp 0/0", count, timeout);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    a_valid = 1'b1;
    a_data  = blk(7);
    tick();
    idle();
    repeat (TIMEOUT - 1) tick();
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early got=%b exp=0", timeout);
    end
    tick();
    vectors++;
    if (timeout !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_flag to=%b ovf=%b exp 1/0", timeout, overflow);
    end
  endtask

  task automatic test_enable();
    do_clear();
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = blk(1); b_data = blk(1);
    tick();
    enable = 1'b0;
    a_data = blk(2); b_data = blk(3);
    tick();
    idle();
    tick();
    vectors++;
    if (count !== 32'd1 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_buffered count=%0d alarm=%b exp 1/0", count, alarm);
    end
    enable = 1'b1;
    a_valid = 1'b1; a_data = blk(9);
    tick();
    enable = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b1; b_data = blk(5);
    tick();
    enable = 1'b1;
    b_data = blk(9);
    tick();
    idle();
    repeat (2) tick();
    vectors++;
    if (count !== 32'd2 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_gated count=%0d alarm=%b exp 2/0", count, alarm);
    end
  endtask

  task automatic test_reset_midstream();
    do_clear();
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = blk(3); b_data = blk(4);
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (alarm !== 1'b0 || count !== '0 || fail_diff !== '0) begin
      miscompares++;
      $display("FAIL reset_async alarm=%b count=%0d exp 0/0", alarm, count);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (alarm !== 1'b0 || count !== '0 || fail_a !== '0) begin
      miscompares++;
      $display("FAIL reset_midstream alarm=%b count=%0d exp 0/0", alarm, count);
    end
  endtask

  initial begin
    test_reset();
    test_fips_pair();
    test_lagged_stream();
    test_mismatch();
    test_clear_recovery();
    test_overflow();
    test_timeout();
    test_enable();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
